// File: rtl/bc_pkg.sv
// BattleChip shared definitions: ship ids and lengths, result codes, resolver states, board geometry.
package bc_pkg;

   localparam int unsigned CELLS     = 100;
   localparam int unsigned SWEEP_W   = 7;
   localparam int unsigned IDX_W     = 7;
   localparam int unsigned ID_W      = 3;
   localparam int unsigned NUM_SHIPS = 5;
   localparam int unsigned CNT_W     = 3;
   localparam int unsigned SHOTS_W   = 7;
   localparam int unsigned HITS_W    = 5;

   localparam logic [ID_W-1:0] ID_EMPTY      = 3'd0;
   localparam logic [ID_W-1:0] ID_DESTROYER  = 3'd1;
   localparam logic [ID_W-1:0] ID_SUB        = 3'd2;
   localparam logic [ID_W-1:0] ID_CRUISER    = 3'd3;
   localparam logic [ID_W-1:0] ID_BATTLESHIP = 3'd4;
   localparam logic [ID_W-1:0] ID_CARRIER    = 3'd5;

   localparam logic [CNT_W-1:0] SHIP_LEN [1:5] = '{3'd2, 3'd3, 3'd3, 3'd4, 3'd5};

   typedef enum logic [2:0] {
      RES_MISS      = 3'd0,
      RES_HIT       = 3'd1,
      RES_SUNK      = 3'd2,
      RES_GAME_OVER = 3'd3,
      RES_REPEAT    = 3'd4,
      RES_ERR       = 3'd5
   } result_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOOK  = 3'd1,
      ST_UPD   = 3'd2,
      ST_SWEEP = 3'd3,
      ST_RESP  = 3'd4
   } state_e;

   // Length of a ship id; empty and unused ids report zero so they can never sink.
   function automatic logic [CNT_W-1:0] ship_len(input logic [ID_W-1:0] id);
      logic [CNT_W-1:0] len;
      len = '0;
      if (id >= ID_DESTROYER && id <= ID_CARRIER) len = SHIP_LEN[id];
      return len;
   endfunction

endpackage

// File: rtl/board_store.sv
// Ship placement memory: one 3-bit ship id per cell, synchronous write and clear,
// two combinational read ports (shot lookup and sink sweep).
module board_store
   import bc_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [ID_W-1:0]  wdata,
   input  logic [IDX_W-1:0] raddr_a,
   output logic [ID_W-1:0]  rdata_a,
   input  logic [IDX_W-1:0] raddr_b,
   output logic [ID_W-1:0]  rdata_b
);

   logic [ID_W-1:0] cells [CELLS];

   // Cell array: cleared by reset or new game, otherwise written one cell at a time.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(CELLS); i++) cells[i] <= '0;
      end else if (clr) begin
         for (int i = 0; i < int'(CELLS); i++) cells[i] <= '0;
      end else if (we && (waddr < IDX_W'(CELLS))) begin
         cells[waddr] <= wdata;
      end
   end

   // Read ports; off-board addresses read as empty water.
   always_comb begin
      rdata_a = '0;
      rdata_b = '0;
      if (raddr_a < IDX_W'(CELLS)) rdata_a = cells[raddr_a];
      if (raddr_b < IDX_W'(CELLS)) rdata_b = cells[raddr_b];
   end

endmodule

// File: rtl/shot_resolver.sv
// Defender-side board keeper: holds ship placement and resolves shots to
// MISS/HIT/SUNK/GAME_OVER/REPEAT/ERR while maintaining fired/hits/ships for the AI.
// Optional build macro SHOT_STATS_EN adds saturating shot_count and hit_count outputs.
module shot_resolver
   import bc_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 new_game,
   input  logic                 place_we,
   input  logic [IDX_W-1:0]     place_index,
   input  logic [ID_W-1:0]      place_id,
   input  logic                 shot_valid,
   input  logic [IDX_W-1:0]     shot_index,
   output logic                 shot_ready,
   output logic                 result_valid,
   output logic [2:0]           result,
   output logic [ID_W-1:0]      sunk_id,
   output logic [CELLS-1:0]     fired,
   output logic [CELLS-1:0]     hits,
   output logic [NUM_SHIPS-1:0] ships
`ifdef SHOT_STATS_EN
   ,
   output logic [SHOTS_W-1:0]   shot_count,
   output logic [HITS_W-1:0]    hit_count
`endif
);

   state_e                        state_q, state_d;
   logic [IDX_W-1:0]              idx_q, idx_d;
   logic [ID_W-1:0]               cid_q, cid_d;
   logic                          seen_q, seen_d;
   logic [SWEEP_W-1:0]            swp_q, swp_d;
   logic [NUM_SHIPS:1][CNT_W-1:0] hcnt_q, hcnt_d;
   logic [2:0]                    pres_q, pres_d;
   logic [ID_W-1:0]               psid_q, psid_d;
   logic [CELLS-1:0]              fired_d, hits_d;
   logic [NUM_SHIPS-1:0]          ships_d;
   logic                          rv_d;
   logic [2:0]                    res_d;
   logic [ID_W-1:0]               sid_d;
   logic [ID_W-1:0]               rd_a_data, rd_b_data;
   logic                          place_ok, idx_ok;
   logic [CNT_W-1:0]              cnt_inc;
`ifdef SHOT_STATS_EN
   logic [SHOTS_W-1:0]            shot_d;
   logic [HITS_W-1:0]             hitc_d;
`endif

   // Placement is only honoured in IDLE, without a competing new game, for legal cells/ids.
   assign place_ok   = (state_q == ST_IDLE) && place_we && !new_game &&
                       (place_index < IDX_W'(CELLS)) && (place_id <= ID_W'(NUM_SHIPS));
   assign shot_ready = (state_q == ST_IDLE) && !new_game && !place_we;
   assign idx_ok     = idx_q < IDX_W'(CELLS);
   assign cnt_inc    = hcnt_q[cid_q] + CNT_W'(1);

   board_store u_board (
      .clk     (clk),
      .rst     (rst),
      .clr     (new_game),
      .we      (place_ok),
      .waddr   (place_index),
      .wdata   (place_id),
      .raddr_a (idx_q),
      .rdata_a (rd_a_data),
      .raddr_b (swp_q),
      .rdata_b (rd_b_data)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next state and next values of every datapath/output register.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cid_d   = cid_q;
      seen_d  = seen_q;
      swp_d   = swp_q;
      hcnt_d  = hcnt_q;
      pres_d  = pres_q;
      psid_d  = psid_q;
      fired_d = fired;
      hits_d  = hits;
      ships_d = ships;
      rv_d    = 1'b0;
      res_d   = '0;
      sid_d   = '0;
`ifdef SHOT_STATS_EN
      shot_d  = shot_count;
      hitc_d  = hit_count;
`endif

      case (state_q)
         ST_IDLE: begin
            if (place_ok) begin
               if (place_id != ID_EMPTY) ships_d[ID_W'(place_id - 3'd1)] = 1'b1;
            end else if (shot_valid && shot_ready) begin
               idx_d   = shot_index;
               state_d = ST_LOOK;
            end
         end
         ST_LOOK: begin
            cid_d   = rd_a_data;
            seen_d  = idx_ok && (fired[idx_q] || hits[idx_q]);
            state_d = ST_UPD;
         end
         ST_UPD: begin
            state_d = ST_RESP;
            psid_d  = '0;
            if (!idx_ok) begin
               pres_d = RES_ERR;
            end else if (seen_q) begin
               pres_d = RES_REPEAT;
            end else if (cid_q == ID_EMPTY) begin
               fired_d[idx_q] = 1'b1;
               pres_d         = RES_MISS;
`ifdef SHOT_STATS_EN
               if (shot_count != '1) shot_d = shot_count + SHOTS_W'(1);
`endif
            end else begin
               hits_d[idx_q] = 1'b1;
               hcnt_d[cid_q] = cnt_inc;
               pres_d        = RES_HIT;
`ifdef SHOT_STATS_EN
               if (shot_count != '1) shot_d = shot_count + SHOTS_W'(1);
               if (hit_count != '1)  hitc_d = hit_count + HITS_W'(1);
`endif
               if (cnt_inc == ship_len(cid_q)) begin
                  swp_d   = '0;
                  state_d = ST_SWEEP;
               end
            end
         end
         ST_SWEEP: begin
            if (rd_b_data == cid_q) begin
               fired_d[swp_q] = 1'b1;
               hits_d[swp_q]  = 1'b0;
            end
            if (swp_q == SWEEP_W'(CELLS - 1)) begin
               ships_d[ID_W'(cid_q - 3'd1)] = 1'b0;
               pres_d  = (ships_d == '0) ? RES_GAME_OVER : RES_SUNK;
               psid_d  = cid_q;
               state_d = ST_RESP;
            end else begin
               swp_d = swp_q + SWEEP_W'(1);
            end
         end
         ST_RESP: begin
            rv_d    = 1'b1;
            res_d   = pres_q;
            sid_d   = psid_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // New game wins over everything and aborts any shot in flight without a result.
      if (new_game) begin
         state_d = ST_IDLE;
         fired_d = '0;
         hits_d  = '0;
         ships_d = '0;
         hcnt_d  = '0;
         pres_d  = '0;
         psid_d  = '0;
         rv_d    = 1'b0;
         res_d   = '0;
         sid_d   = '0;
`ifdef SHOT_STATS_EN
         shot_d  = '0;
         hitc_d  = '0;
`endif
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q        <= '0;
         cid_q        <= '0;
         seen_q       <= 1'b0;
         swp_q        <= '0;
         hcnt_q       <= '0;
         pres_q       <= '0;
         psid_q       <= '0;
         fired        <= '0;
         hits         <= '0;
         ships        <= '0;
         result_valid <= 1'b0;
         result       <= '0;
         sunk_id      <= '0;
`ifdef SHOT_STATS_EN
         shot_count   <= '0;
         hit_count    <= '0;
`endif
      end else begin
         idx_q        <= idx_d;
         cid_q        <= cid_d;
         seen_q       <= seen_d;
         swp_q        <= swp_d;
         hcnt_q       <= hcnt_d;
         pres_q       <= pres_d;
         psid_q       <= psid_d;
         fired        <= fired_d;
         hits         <= hits_d;
         ships        <= ships_d;
         result_valid <= rv_d;
         result       <= res_d;
         sunk_id      <= sid_d;
`ifdef SHOT_STATS_EN
         shot_count   <= shot_d;
         hit_count    <= hitc_d;
`endif
      end
   end

endmodule
